// File: rtl/uart_pkg.sv
// Shared UART types and constants: scheduler state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int unsigned UART_DIV_DEFAULT = 104;
    localparam int unsigned FRAME_BITS       = 10;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte handshake between a byte-producing source and the UART transmit scheduler.
interface uart_tx_sched_if;

    logic [7:0] DATA;
    logic       VALID;
    logic       READY;

    modport master (output DATA, output VALID, input READY);
    modport slave  (input DATA, input VALID, output READY);

endinterface

// File: rtl/uart_tx_sched_baud_tick.sv
// Baud divider: 8-bit counter 0..DIV-1 with a one-cycle tick on the last count.
module uart_baud_tick #(
    parameter int unsigned DIV = 104
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLR,
    output logic [7:0] cnt,
    output logic       TICK
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    assign TICK = (cnt == LAST);

    // DIV=256 wraps 255->0 through the natural 8-bit overflow and the tick clear alike.
    always_ff @(posedge CLK) begin
        if (RESET || CLR || TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// 8N1 transmit scheduler: accepts one byte per frame and steps start/data/stop bits on divider ticks.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned DIV = UART_DIV_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    uart_tx_sched_if.slave    bus,
    output logic              TX,
    output logic              BUSY
);

    state_t     state;
    state_t     state_next;
    logic [7:0] shreg;
    logic [7:0] shreg_next;
    logic [2:0] idx;
    logic [2:0] idx_next;
    logic       tx_next;
    logic [7:0] cnt;
    logic       tick;
    logic       ready;
    logic       transfer;
    logic       clr;

    assign ready    = !RESET && ((state == IDLE) || (state == STOP && tick));
    assign transfer = bus.VALID && ready;
    assign clr      = (state == IDLE) || transfer;
    assign bus.READY = ready;
    assign BUSY      = (state != IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (clr),
        .cnt   (cnt),
        .TICK  (tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            TX    <= 1'b1;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            idx   <= idx_next;
            TX    <= tx_next;
            assert (state != IDLE || cnt == '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (transfer) state_next = START;
            START:   if (tick) state_next = DATA;
            DATA:    if (tick && idx == 3'd7) state_next = STOP;
            STOP:    if (tick) state_next = transfer ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // TX is registered from the next-state view so the pin changes on the same edge as the state.
    always_comb begin
        shreg_next = shreg;
        idx_next   = idx;
        if (transfer) begin
            shreg_next = bus.DATA;
            idx_next   = '0;
        end else if (state == DATA && tick) begin
            shreg_next = {1'b0, shreg[7:1]};
            idx_next   = idx + 3'd1;
        end
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset, single, back-to-back, busy-ignore, mid-frame reset, DIV=2.
module tb_uart_tx_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx4, busy4, tx2, busy2;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    uart_tx_sched_if bus4 ();
    uart_tx_sched_if bus2 ();

    uart_tx_sched #(.DIV(4)) dut4 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus4.slave),
        .TX    (tx4),
        .BUSY  (busy4)
    );

    uart_tx_sched #(.DIV(2)) dut2 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus2.slave),
        .TX    (tx2),
        .BUSY  (busy2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level i cycles into a frame of byte d: start, 8 data LSB first, stop.
    function automatic logic exp_bit(input logic [7:0] d, input int unsigned div, input int unsigned i);
        int unsigned b;
        b = i / div;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Checks a whole DIV=4 frame starting in the cycle after the transfer edge.
    task automatic frame4(input string tag, input logic [7:0] d);
        for (int unsigned i = 0; i < 40; i++) begin
            check({tag, "_tx"}, 32'(tx4), 32'(exp_bit(d, 4, i)));
            check({tag, "_busy"}, 32'(busy4), 32'd1);
            check({tag, "_ready"}, 32'(bus4.READY), 32'(i == 39));
            step();
        end
    endtask

    initial begin
        bus4.VALID = 1'b1;
        bus4.DATA  = 8'h5A;
        bus2.VALID = 1'b0;
        bus2.DATA  = 8'h00;

        // Reset held 3 cycles with VALID high
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            check("rst_tx", 32'(tx4), 32'd1);
            check("rst_busy", 32'(busy4), 32'd0);
            check("rst_ready", 32'(bus4.READY), 32'd0);
        end
        bus4.VALID = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus4.READY), 32'd1);
        step();
        check("post_rst_busy", 32'(busy4), 32'd0);
        check("post_rst_tx", 32'(tx4), 32'd1);

        // Single byte 0xA5
        bus4.DATA  = 8'hA5;
        bus4.VALID = 1'b1;
        step();
        bus4.VALID = 1'b0;
        frame4("single", 8'hA5);
        check("single_end_busy", 32'(busy4), 32'd0);
        check("single_end_tx", 32'(tx4), 32'd1);
        step();

        // Back-to-back 0x00 then 0xFF with VALID held
        bus4.DATA  = 8'h00;
        bus4.VALID = 1'b1;
        step();
        bus4.DATA = 8'hFF;
        for (int unsigned i = 0; i < 80; i++) begin
            check("b2b_tx", 32'(tx4), 32'(exp_bit((i < 40) ? 8'h00 : 8'hFF, 4, i % 40)));
            check("b2b_busy", 32'(busy4), 32'd1);
            if (i == 79) bus4.VALID = 1'b0;
            step();
        end
        check("b2b_end_busy", 32'(busy4), 32'd0);
        step();

        // Busy ignore: 0x3C in flight, 0xC3 offered at k+10
        bus4.DATA  = 8'h3C;
        bus4.VALID = 1'b1;
        step();
        bus4.VALID = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            check("ign_tx", 32'(tx4), 32'(exp_bit(8'h3C, 4, i)));
            check("ign_ready", 32'(bus4.READY), 32'(i == 39));
            if (i == 9) begin
                bus4.DATA  = 8'hC3;
                bus4.VALID = 1'b1;
            end
            step();
        end
        bus4.VALID = 1'b0;
        frame4("ign2", 8'hC3);
        check("ign2_end_busy", 32'(busy4), 32'd0);
        step();

        // Reset during data bit 3 (frame cycles 16..19)
        bus4.DATA  = 8'h81;
        bus4.VALID = 1'b1;
        step();
        bus4.VALID = 1'b0;
        for (int unsigned i = 0; i < 17; i++) step();
        check("mid_pre_busy", 32'(busy4), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_tx", 32'(tx4), 32'd1);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_ready", 32'(bus4.READY), 32'd0);
        rst = 1'b0;
        step();
        check("mid_idle_tx", 32'(tx4), 32'd1);
        check("mid_idle_busy", 32'(busy4), 32'd0);
        bus4.VALID = 1'b1;
        step();
        bus4.VALID = 1'b0;
        frame4("mid_new", 8'h81);
        check("mid_new_end_busy", 32'(busy4), 32'd0);

        // Minimum divider DIV=2, 0x55
        bus2.DATA  = 8'h55;
        bus2.VALID = 1'b1;
        step();
        bus2.VALID = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            check("div2_tx", 32'(tx2), 32'(exp_bit(8'h55, 2, i)));
            check("div2_busy", 32'(busy2), 32'd1);
            step();
        end
        check("div2_end_busy", 32'(busy2), 32'd0);
        check("div2_end_tx", 32'(tx2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
